// File: rtl/pio_saida_pkg.sv
// Shared definitions for the output PIO: register addresses, STATUS/read bit
// positions and the pulse-timer state type.
package pio_saida_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_LEN    = 2'd1;
  localparam logic [1:0] ADDR_PULSE  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int DONE_BIT  = 0;
  localparam int IRQEN_BIT = 1;
  localparam int BUSY_BIT  = 31;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/sistema_ransac_pio_saida_if.sv
// Avalon-MM slave bus bundle for the output PIO.
//   address    : register select (2 bits)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : 32-bit write data
//   readdata   : 32-bit registered read data
// modport slave is used by the PIO, modport master by whoever drives the bus.
interface sistema_ransac_pio_saida_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport slave  (input address, chipselect, write_n, writedata, output readdata);
  modport master (output address, chipselect, write_n, writedata, input readdata);
endinterface

// File: rtl/pio_saida_pulse_timer.sv
// One-shot pulse timer for the output PIO.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   trig       : PULSE register write this cycle
//   mask       : bits to pulse (from writedata)
//   len        : programmed pulse length in cycles
//   mask_nxt   : mask that will be active after the coming edge (0 when IDLE)
//   busy       : timer is ACTIVE
//   count      : remaining high cycles of the running pulse
//   done_set   : one-cycle request to set the done flag at the coming edge
module pio_saida_pulse_timer
  import pio_saida_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  trig,
  input  logic [DATA_WIDTH-1:0] mask,
  input  logic [CNT_WIDTH-1:0]  len,
  output logic [DATA_WIDTH-1:0] mask_nxt,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  done_set
);

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [DATA_WIDTH-1:0] mask_q,  mask_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mask_q  <= mask_d;
    end
  end

  // mask_q is kept at zero whenever IDLE, so the next mask alone tells the
  // top level which bits are pulsed after the edge.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mask_d   = mask_q;
    done_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig) begin
          if ((len != '0) && (mask != '0)) begin
            state_d = ACTIVE;
            mask_d  = mask;
            count_d = len;
          end else begin
            done_set = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (trig) begin
          // Retrigger: widen the mask and restart; zero length ends at once.
          if (len == '0) begin
            state_d  = IDLE;
            mask_d   = '0;
            count_d  = '0;
            done_set = 1'b1;
          end else begin
            mask_d  = mask_q | mask;
            count_d = len;
          end
        end else if (count_q == CNT_WIDTH'(1)) begin
          state_d  = IDLE;
          mask_d   = '0;
          count_d  = '0;
          done_set = 1'b1;
        end else begin
          count_d = count_q - CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        mask_d  = '0;
        count_d = '0;
      end
    endcase
  end

  assign mask_nxt = mask_d;
  assign busy     = (state_q == ACTIVE);
  assign count    = count_q;

endmodule

// File: rtl/sistema_ransac_pio_saida.sv
// Avalon-MM output PIO with static level register and hardware-timed pulses.
// Optional feature macro: PIO_SAIDA_IRQ_EN (adds irq port and STATUS.irq_en).
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
//   out_port   : registered output pins = data | active pulse mask
//   irq        : registered done & irq_en (only with PIO_SAIDA_IRQ_EN)
// Registers: 0 DATA, 1 PULSE_LEN, 2 PULSE (read: busy/count), 3 STATUS.
module sistema_ransac_pio_saida
  import pio_saida_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    CNT_WIDTH   = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  sistema_ransac_pio_saida_if.slave bus,
  output logic [DATA_WIDTH-1:0] out_port
`ifdef PIO_SAIDA_IRQ_EN
  ,
  output logic                  irq
`endif
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]  len_q, len_d;
  logic                  done_q, done_d;
  logic [31:0]           readdata_q, readdata_d;
  logic [DATA_WIDTH-1:0] out_port_q, out_port_d;
`ifdef PIO_SAIDA_IRQ_EN
  logic                  irq_en_q, irq_en_d;
  logic                  irq_q, irq_d;
`endif

  logic                  wr;
  logic                  trig;
  logic [DATA_WIDTH-1:0] mask_nxt;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  count;
  logic                  done_set;
  logic                  unused_wdata;

  assign wr           = bus.chipselect & ~bus.write_n;
  assign trig         = wr && (bus.address == ADDR_PULSE);
  assign unused_wdata = ^bus.writedata;

  pio_saida_pulse_timer #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .trig     (trig),
    .mask     (bus.writedata[DATA_WIDTH-1:0]),
    .len      (len_q),
    .mask_nxt (mask_nxt),
    .busy     (busy),
    .count    (count),
    .done_set (done_set)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q     <= RESET_VALUE;
      len_q      <= '0;
      done_q     <= 1'b0;
      readdata_q <= '0;
      out_port_q <= RESET_VALUE;
`ifdef PIO_SAIDA_IRQ_EN
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
`endif
    end else begin
      data_q     <= data_d;
      len_q      <= len_d;
      done_q     <= done_d;
      readdata_q <= readdata_d;
      out_port_q <= out_port_d;
`ifdef PIO_SAIDA_IRQ_EN
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
`endif
    end
  end

  always_comb begin
    data_d = data_q;
    len_d  = len_q;
    done_d = done_q;
`ifdef PIO_SAIDA_IRQ_EN
    irq_en_d = irq_en_q;
`endif
    if (wr && (bus.address == ADDR_DATA))
      data_d = bus.writedata[DATA_WIDTH-1:0];
    if (wr && (bus.address == ADDR_LEN))
      len_d = bus.writedata[CNT_WIDTH-1:0];
    if (wr && (bus.address == ADDR_STATUS)) begin
      if (bus.writedata[DONE_BIT])
        done_d = 1'b0;
`ifdef PIO_SAIDA_IRQ_EN
      irq_en_d = bus.writedata[IRQEN_BIT];
`endif
    end
    // A completion in the same cycle as a software clear keeps done set.
    if (done_set)
      done_d = 1'b1;

    out_port_d = data_d | mask_nxt;

`ifdef PIO_SAIDA_IRQ_EN
    irq_d = done_q & irq_en_q;
`endif
  end

  // Read mux: address only, no read strobe; result lands one edge later.
  always_comb begin
    readdata_d = '0;
    case (bus.address)
      ADDR_DATA:  readdata_d = 32'(data_q);
      ADDR_LEN:   readdata_d = 32'(len_q);
      ADDR_PULSE: begin
        readdata_d           = 32'(count);
        readdata_d[BUSY_BIT] = busy;
      end
      default: begin
        readdata_d[DONE_BIT] = done_q;
`ifdef PIO_SAIDA_IRQ_EN
        readdata_d[IRQEN_BIT] = irq_en_q;
`endif
      end
    endcase
  end

  assign bus.readdata = readdata_q;
  assign out_port     = out_port_q;
`ifdef PIO_SAIDA_IRQ_EN
  assign irq          = irq_q;
`endif

endmodule

// File: tb/tb_sistema_ransac_pio_saida.sv
// Testbench for sistema_ransac_pio_saida: directed scenarios followed by
// randomized bus traffic, checked against a cycle-level behavioural model
// through an expectation queue drained by an independent monitor.
module tb_sistema_ransac_pio_saida;

  localparam int          DW = 8;
  localparam int          CW = 16;
  localparam logic [7:0]  RV = 8'hA5;

  logic clk = 1'b0;
  logic reset;
  logic [DW-1:0] out_port;
`ifdef PIO_SAIDA_IRQ_EN
  logic irq;
`endif

  always #5 clk = ~clk;

  sistema_ransac_pio_saida_if bus_if ();

  sistema_ransac_pio_saida #(
    .DATA_WIDTH  (DW),
    .CNT_WIDTH   (CW),
    .RESET_VALUE (RV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus_if),
    .out_port (out_port)
`ifdef PIO_SAIDA_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  typedef struct {
    logic [7:0]  out;
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Model state: pulses are tracked as "mask held for rem more cycles".
  logic [7:0]  m_data;
  logic [15:0] m_len;
  logic [7:0]  m_mask;
  int          m_rem;
  logic        m_done;
  logic        m_irqen;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  task automatic model_reset();
    m_data  = RV;
    m_len   = '0;
    m_mask  = '0;
    m_rem   = 0;
    m_done  = 1'b0;
    m_irqen = 1'b0;
  endtask

  // One bus cycle: drive at the falling edge, predict the state after the
  // following rising edge and queue it for the monitor.
  task automatic drive(input logic [1:0] a, input logic cs, input logic wn,
                       input logic [31:0] wd);
    exp_t        e;
    logic [31:0] rd;
    logic        wr, set_done;
    @(negedge clk);
    bus_if.address    = a;
    bus_if.chipselect = cs;
    bus_if.write_n    = wn;
    bus_if.writedata  = wd;

    rd = '0;
    case (a)
      2'd0: rd = {24'd0, m_data};
      2'd1: rd = {16'd0, m_len};
      2'd2: rd = {(m_rem > 0), 15'd0, 16'(m_rem)};
      default: rd = {30'd0, m_irqen, m_done};
    endcase
    e.rd  = rd;
    e.irq = m_done & m_irqen;

    wr       = cs && !wn;
    set_done = 1'b0;
    if (m_rem > 0) begin
      if (wr && a == 2'd2) begin
        if (m_len == 0) begin
          m_rem = 0; m_mask = '0; set_done = 1'b1;
        end else begin
          m_mask = m_mask | wd[7:0]; m_rem = int'(m_len);
        end
      end else begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_mask = '0; set_done = 1'b1;
        end
      end
    end else if (wr && a == 2'd2) begin
      if (m_len != 0 && wd[7:0] != 0) begin
        m_mask = wd[7:0]; m_rem = int'(m_len);
      end else begin
        set_done = 1'b1;
      end
    end
    if (wr && a == 2'd0) m_data = wd[7:0];
    if (wr && a == 2'd1) m_len  = wd[15:0];
    if (wr && a == 2'd3) begin
      if (wd[0]) m_done = 1'b0;
`ifdef PIO_SAIDA_IRQ_EN
      m_irqen = wd[1];
`endif
    end
    if (set_done) m_done = 1'b1;

    e.out = m_data | m_mask;
    exp_q.push_back(e);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] wd);
    drive(a, 1'b1, 1'b0, wd);
  endtask

  task automatic idle(input logic [1:0] a, input int n);
    for (int i = 0; i < n; i++) drive(a, 1'b0, 1'b1, $urandom);
  endtask

  // Monitor: one expectation per rising edge, sampled just after it.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("out_port", 32'(out_port), 32'(e.out));
      chk("readdata", bus_if.readdata, e.rd);
`ifdef PIO_SAIDA_IRQ_EN
      chk("irq", 32'(irq), 32'(e.irq));
`endif
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus_if.address    = 2'd0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = '0;
    model_reset();
    #1;
    chk("reset_out_port", 32'(out_port), 32'(RV));
    chk("reset_readdata", bus_if.readdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset value readback and static level
    idle(2'd0, 2);
    wr_reg(2'd0, 32'h3C);
    idle(2'd0, 2);

    // Single pulse, status read mid-pulse and after
    wr_reg(2'd0, 32'h00);
    wr_reg(2'd1, 32'd5);
    wr_reg(2'd2, 32'h81);
    idle(2'd2, 3);
    idle(2'd3, 4);

    // Zero-length trigger
    wr_reg(2'd3, 32'h1);
    wr_reg(2'd1, 32'd0);
    wr_reg(2'd2, 32'h01);
    idle(2'd3, 2);

    // Retrigger, overlap and data write mid-pulse
    wr_reg(2'd3, 32'h1);
    wr_reg(2'd1, 32'd10);
    wr_reg(2'd2, 32'h01);
    idle(2'd2, 3);
    wr_reg(2'd2, 32'h02);
    idle(2'd2, 3);
    wr_reg(2'd0, 32'h10);
    wr_reg(2'd1, 32'd2);
    idle(2'd2, 10);
    idle(2'd0, 2);

    // Ignored writes without chipselect
    drive(2'd0, 1'b0, 1'b0, 32'hFF);
    drive(2'd2, 1'b0, 1'b0, 32'hFF);
    idle(2'd0, 2);

    // Interrupt enable, done, and clear
    wr_reg(2'd3, 32'h2);
    wr_reg(2'd1, 32'd3);
    wr_reg(2'd2, 32'h04);
    idle(2'd3, 5);
    wr_reg(2'd3, 32'h3);
    idle(2'd3, 3);

    // Reset in the middle of a pulse
    wr_reg(2'd1, 32'd8);
    wr_reg(2'd2, 32'hF0);
    idle(2'd0, 2);
    @(negedge clk);
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("midpulse_reset_out_port", 32'(out_port), 32'(RV));
    chk("midpulse_reset_readdata", bus_if.readdata, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    idle(2'd3, 2);
    idle(2'd2, 2);
    idle(2'd0, 2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [1:0]  a;
      logic [31:0] wd;
      a = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        wd = $urandom;
        if (a == 2'd1) wd = 32'($urandom_range(0, 12));
        if (a == 2'd2 && $urandom_range(0, 3) == 0) wd = 32'h0;
        wr_reg(a, wd);
      end else begin
        idle(a, 1);
      end
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sistema_ransac_pio_saida.md
Name: sistema_ransac_pio_saida

Overview:
- Avalon-MM slave output PIO: the write-side counterpart of the system's read-only input PIO.
- Nios II software drives out_port either as a static level register or with hardware-timed one-shot pulses of a programmable length, so the CPU does not have to bit-bang the timing.
- Sits on the system interconnect alongside the input PIO, with the same register-read timing.

Parameters:
- DATA_WIDTH, 8: width of out_port and of the data and mask registers (1..32).
- CNT_WIDTH, 16: width of the pulse-length counter (1..32).
- RESET_VALUE, 0: reset value of the DATA register and of out_port.

Ports:
- clk  in  1  system clock; every register is clocked on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write happens when chipselect=1 and write_n=0.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- out_port  out  DATA_WIDTH  registered output pins.
- irq  out  1  interrupt request; present only when PIO_SAIDA_IRQ_EN is defined.

Behaviour:
- Reset: data_reg=RESET_VALUE, out_port=RESET_VALUE, len_reg=0, mask_reg=0, count=0, done=0, irq_en=0, readdata=0, irq=0, state=IDLE.
- Register map, by address:
  - 0 DATA (R/W): static level; write loads writedata[DATA_WIDTH-1:0]. Read returns data_reg.
  - 1 PULSE_LEN (R/W): pulse length in clk cycles, writedata[CNT_WIDTH-1:0]. Read returns len_reg.
  - 2 PULSE (W; read returns status): a write triggers a pulse on the bits set in writedata[DATA_WIDTH-1:0]. Read returns {busy at bit 31, count at [CNT_WIDTH-1:0]}, all other bits 0.
  - 3 STATUS: bit0 done; writing 1 to bit0 clears it. Bit1 irq_en (R/W, only with the macro; otherwise reads 0 and writes are ignored).
- Read: readdata updates every clock from address with a mux on address only (no read strobe). Latency is 1 cycle. Unused upper bits read 0.
- Output rule, registered: out_port <= next_data_reg | (next state==ACTIVE ? next mask_reg : 0). out_port changes one edge after the write edge, or the same edge as a state change.
- FSM states: IDLE and ACTIVE.
  - IDLE, PULSE write with len_reg>0 and nonzero mask: mask_reg<=mask, count<=len_reg, go to ACTIVE. Mask bits are high on out_port for exactly len_reg cycles.
  - IDLE, PULSE write with len_reg=0 or mask=0: no pulse; done<=1 at that edge; state stays IDLE.
  - ACTIVE: count decrements each cycle.
  - ACTIVE, count==1: go to IDLE, mask_reg<=0, done<=1, all at the same edge.
  - ACTIVE, PULSE write (retrigger): mask_reg<=mask_reg|mask, count<=len_reg; remain ACTIVE. If len_reg=0, terminate immediately as at count==1.
- Simultaneous events:
  - DATA write while ACTIVE: data_reg updates; pulsed bits stay high until the pulse ends, then fall to the new data_reg value.
  - PULSE_LEN write while ACTIVE: does not affect the running count.
  - done set and STATUS clear in the same cycle: set wins.
- Writes with chipselect=0 are ignored.
- Reset mid-pulse: everything returns to reset values asynchronously; no done flag is set.

Optional Feature:
- Macro: PIO_SAIDA_IRQ_EN.
- Defined: irq port exists; irq = done & irq_en, registered, and clears one edge after done is cleared. STATUS bit1 is writable and readable.
- Undefined: no irq port; STATUS bit1 reads 0 and writes to it are ignored.

Decomposition:
- Shared package pio_saida_pkg:
  - Register address constants ADDR_DATA=0, ADDR_LEN=1, ADDR_PULSE=2, ADDR_STATUS=3.
  - STATUS bit indices DONE_BIT=0, IRQEN_BIT=1.
  - BUSY_BIT=31.
  - State enum typedef {IDLE, ACTIVE}.
- One sub-module, pio_saida_pulse_timer: holds the FSM, count and mask_reg; inputs are the trigger, mask and len; outputs are the active mask and the done pulse. The top level holds the registers, read mux and output OR.

Test Plan:
- Reset check: reset asserted with RESET_VALUE=8'hA5 -> out_port=8'hA5, readdata=0; after release, read addr0 -> readdata=0xA5 one cycle later.
- Static write: write addr0=0x3C -> out_port=0x3C one edge after the write; read addr0 returns 0x3C.
- Pulse: len=5, data=0x00, write PULSE=0x81 -> out_port=0x81 for exactly 5 cycles then 0x00; done=1 at the falling edge; reading addr2 mid-pulse shows bit31=1 and count decreasing.
- Zero length: len=0, write PULSE=0x01 -> out_port never changes; done=1 the next cycle.
- Retrigger and overlap:
  - len=10, PULSE=0x01, then after 4 cycles PULSE=0x02 -> out_port=0x03 for 10 more cycles.
  - DATA=0x10 written mid-pulse -> out_port=0x13, then 0x10 after the pulse ends.
- IRQ (macro defined), plus reset mid-pulse:
  - irq_en=1, len=3 pulse -> irq rises with done; writing STATUS=0x1 drops irq next edge.
  - Reset asserted mid-pulse -> out_port=RESET_VALUE immediately and done=0.
